// File: rtl/dm_param.sv
// ============================================================================
// Module   : dm_param
// Brief    : Byte-addressed data memory with configurable depth and latency,
//            req/ready/rvalid handshake. Optional macro: DM_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_param #(
    parameter int ADDR_W    = 12,
    parameter int LATENCY   = 1,
    parameter int INIT_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       din,
    output logic              ready,
    output logic              rvalid,
    output logic [31:0]       dout,
    output logic              misalign
);

    localparam int         c_DEPTH  = 2 ** (ADDR_W - 2);
    localparam logic [3:0] c_LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_sext;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_din;

    logic              w_accept;
    logic              w_commit;
    logic              w_mis;
    logic [1:0]        w_lane;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic              w_wr_en;
    logic [ADDR_W-3:0] w_idx;
    logic [31:0]       w_rd_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;

    assign ready    = (r_state == S_IDLE);
    assign w_accept = (r_state == S_IDLE) && req;
    assign w_commit = (r_state == S_BUSY) && (r_cnt == 4'd0);
    assign w_idx    = r_addr[ADDR_W-1:2];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (req) w_state_nxt = S_BUSY;
            S_BUSY:  if (r_cnt == 4'd0) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef DM_MISALIGN_TRAP_EN
    // Misaligned accesses complete without side effects, so the raw lane is safe.
    assign w_mis  = ((r_size == 2'b01) && r_addr[0]) ||
                    (r_size[1] && (r_addr[1:0] != 2'b00));
    assign w_lane = r_addr[1:0];
`else
    assign w_mis = 1'b0;
    always_comb begin
        w_lane = 2'b00;
        case (r_size)
            2'b00:   w_lane = r_addr[1:0];
            2'b01:   w_lane = {r_addr[1], 1'b0};
            default: w_lane = 2'b00;
        endcase
    end
`endif

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_din;
        case (r_size)
            2'b00: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{r_din[7:0]}};
            end
            2'b01: begin
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_din[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = r_din;
            end
        endcase
    end

    assign w_wr_en = w_commit && r_we && !w_mis;

    if (INIT_ZERO != 0) begin : g_mem_zero
        logic [31:0] r_mem [c_DEPTH] = '{default: 32'h0};
        always_ff @(posedge clk) begin
            if (w_wr_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
        assign w_rd_word = r_mem[w_idx];
    end else begin : g_mem_x
        logic [31:0] r_mem [c_DEPTH];
        always_ff @(posedge clk) begin
            if (w_wr_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
        assign w_rd_word = r_mem[w_idx];
    end

    always_comb begin
        w_byte = w_rd_word[{w_lane, 3'b000} +: 8];
        w_half = w_lane[1] ? w_rd_word[31:16] : w_rd_word[15:0];
        case (r_size)
            2'b00:   w_load = {{24{r_sext & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{r_sext & w_half[15]}}, w_half};
            default: w_load = w_rd_word;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_we     <= 1'b0;
            r_size   <= 2'b00;
            r_sext   <= 1'b0;
            r_addr   <= '0;
            r_din    <= 32'h0;
            rvalid   <= 1'b0;
            misalign <= 1'b0;
            dout     <= 32'h0;
        end else begin
            r_state  <= w_state_nxt;
            rvalid   <= w_commit;
            misalign <= w_commit && w_mis;
            if (w_accept) begin
                r_cnt  <= c_LAT_M1;
                r_we   <= we;
                r_size <= size;
                r_sext <= sext;
                r_addr <= addr;
                r_din  <= din;
            end else if ((r_state == S_BUSY) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // dout only moves on a successful load; stores and traps leave it alone.
            if (w_commit && !r_we && !w_mis) dout <= w_load;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dm_param.sv
// ============================================================================
// Module   : tb_dm_param
// Brief    : Scoreboard bench for dm_param (LATENCY=1 and LATENCY=3 instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dm_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req [2];
    logic        we [2];
    logic        sext [2];
    logic [1:0]  size [2];
    logic [11:0] addr [2];
    logic [31:0] din [2];
    logic        ready [2];
    logic        rvalid [2];
    logic        misalign [2];
    logic [31:0] dout [2];

    dm_param #(.ADDR_W(12), .LATENCY(1), .INIT_ZERO(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .req(req[0]), .we(we[0]), .size(size[0]),
        .sext(sext[0]), .addr(addr[0]), .din(din[0]), .ready(ready[0]),
        .rvalid(rvalid[0]), .dout(dout[0]), .misalign(misalign[0])
    );

    dm_param #(.ADDR_W(12), .LATENCY(3), .INIT_ZERO(1)) u_dut_l3 (
        .clk(clk), .rst_n(rst_n), .req(req[1]), .we(we[1]), .size(size[1]),
        .sext(sext[1]), .addr(addr[1]), .din(din[1]), .ready(ready[1]),
        .rvalid(rvalid[1]), .dout(dout[1]), .misalign(misalign[1])
    );

    typedef struct {
        string       tag;
        logic [31:0] dout;
        logic        mis;
        int          cyc;
    } exp_t;

    exp_t        sb [2][$];
    exp_t        mon_e;
    logic [7:0]  mm [2][4096];
    logic [31:0] last [2];
    int          checks = 0;
    int          errors = 0;
    int          ncyc = 0;
    int          acc_cyc [2];

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: byte array per instance plus last loaded value.
    task automatic model(input int d, input logic w, input logic [1:0] sz, input logic sx,
                         input logic [11:0] a, input logic [31:0] dat,
                         output logic [31:0] od, output logic om);
        int n, aa;
        logic [31:0] v;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
`ifdef DM_MISALIGN_TRAP_EN
        om = (int'(a) % n) != 0;
        aa = int'(a);
`else
        om = 1'b0;
        aa = int'(a) - (int'(a) % n);
`endif
        v = 32'h0;
        if (om) begin
            od = last[d];
        end else if (w) begin
            for (int i = 0; i < n; i++) mm[d][aa+i] = dat[8*i +: 8];
            od = last[d];
        end else begin
            for (int i = 0; i < n; i++) v[8*i +: 8] = mm[d][aa+i];
            if (sx && n == 1) v = {{24{v[7]}}, v[7:0]};
            if (sx && n == 2) v = {{16{v[15]}}, v[15:0]};
            last[d] = v;
            od = v;
        end
    endtask

    always @(negedge clk) begin
        ncyc++;
        for (int d = 0; d < 2; d++) begin
            if (rvalid[d] === 1'b1) begin
                if (sb[d].size() == 0) begin
                    chk($sformatf("unexpected_rvalid_dut%0d", d), 32'd1, 32'd0);
                end else begin
                    mon_e = sb[d].pop_front();
                    chk({mon_e.tag, "_dout"}, dout[d], mon_e.dout);
                    chk({mon_e.tag, "_misalign"}, {31'd0, misalign[d]}, {31'd0, mon_e.mis});
                    chk({mon_e.tag, "_cycle"}, 32'(ncyc), 32'(mon_e.cyc));
                    chk({mon_e.tag, "_ready"}, {31'd0, ready[d]}, 32'd1);
                end
            end else if (rst_n === 1'b1) begin
                chk($sformatf("misalign_idle_dut%0d", d), {31'd0, misalign[d]}, 32'd0);
            end
        end
    end

    // Called at negedge+1; returns at posedge+1 of the accepting edge.
    task automatic issue(input int d, input string tag, input logic w, input logic [1:0] sz,
                         input logic sx, input logic [11:0] a, input logic [31:0] dat,
                         input bit hold, input bit track);
        exp_t e;
        int   k;
        k = 0;
        while (ready[d] !== 1'b1 && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk({tag, "_ready_wait"}, {31'd0, ready[d]}, 32'd1);
        req[d]  = 1'b1;
        we[d]   = w;
        size[d] = sz;
        sext[d] = sx;
        addr[d] = a;
        din[d]  = dat;
        acc_cyc[d] = ncyc;
        if (track) begin
            model(d, w, sz, sx, a, dat, e.dout, e.mis);
            e.tag = tag;
            e.cyc = ncyc + 1 + lat(d);
            sb[d].push_back(e);
        end
        @(posedge clk);
        #1;
        if (!hold) req[d] = 1'b0;
    endtask

    task automatic drain(input int d, input string tag);
        int k;
        k = 0;
        while (sb[d].size() != 0 && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk({tag, "_drain"}, 32'(sb[d].size()), 32'd0);
    endtask

    initial begin
        int prev;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; size[d] = 2'b00; sext[d] = 1'b0;
            addr[d] = 12'h0; din[d] = 32'h0; last[d] = 32'h0;
            for (int i = 0; i < 4096; i++) mm[d][i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_ready%0d", d), {31'd0, ready[d]}, 32'd1);
            chk($sformatf("reset_rvalid%0d", d), {31'd0, rvalid[d]}, 32'd0);
            chk($sformatf("reset_dout%0d", d), dout[d], 32'h0);
            chk($sformatf("reset_misalign%0d", d), {31'd0, misalign[d]}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // Basic loads/stores on the LATENCY=1 instance.
        issue(0, "ld_w_010", 1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 1'b0, 1'b1);
        drain(0, "ld_w_010");
        issue(0, "st_w_020", 1'b1, 2'd2, 1'b0, 12'h020, 32'hDEADBEEF, 1'b0, 1'b1);
        issue(0, "st_b_021", 1'b1, 2'd0, 1'b0, 12'h021, 32'hFFFFFF11, 1'b0, 1'b1);
        issue(0, "ld_w_020", 1'b0, 2'd2, 1'b0, 12'h020, 32'h0, 1'b0, 1'b1);
        issue(0, "ld_bs_023", 1'b0, 2'd0, 1'b1, 12'h023, 32'h0, 1'b0, 1'b1);
        issue(0, "ld_bz_023", 1'b0, 2'd0, 1'b0, 12'h023, 32'h0, 1'b0, 1'b1);
        issue(0, "ld_hs_022", 1'b0, 2'd1, 1'b1, 12'h022, 32'h0, 1'b0, 1'b1);
        issue(0, "ld_w11_020", 1'b0, 2'd3, 1'b1, 12'h020, 32'h0, 1'b0, 1'b1);
        drain(0, "basic");

        // Back-to-back with req held high on the LATENCY=3 instance.
        issue(1, "b2b_st_w", 1'b1, 2'd2, 1'b0, 12'h100, 32'hA0A0A0A0, 1'b1, 1'b1);
        prev = acc_cyc[1];
        issue(1, "b2b_st_b", 1'b1, 2'd0, 1'b0, 12'h101, 32'h0000005B, 1'b1, 1'b1);
        chk("b2b_gap1", 32'(acc_cyc[1] - prev), 32'd4);
        prev = acc_cyc[1];
        issue(1, "b2b_ld_w", 1'b0, 2'd2, 1'b0, 12'h100, 32'h0, 1'b1, 1'b1);
        chk("b2b_gap2", 32'(acc_cyc[1] - prev), 32'd4);
        prev = acc_cyc[1];
        issue(1, "b2b_ld_bs", 1'b0, 2'd0, 1'b1, 12'h103, 32'h0, 1'b0, 1'b1);
        chk("b2b_gap3", 32'(acc_cyc[1] - prev), 32'd4);
        drain(1, "b2b");

        // Reset while a store is in flight: no write, no completion.
        @(negedge clk);
        #1;
        issue(0, "st_abandon", 1'b1, 2'd2, 1'b0, 12'h040, 32'h12345678, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_busy_ready", {31'd0, ready[0]}, 32'd1);
        chk("rst_busy_rvalid", {31'd0, rvalid[0]}, 32'd0);
        chk("rst_busy_dout", dout[0], 32'h0);
        last[0] = 32'h0;
        last[1] = 32'h0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        issue(0, "ld_w_040", 1'b0, 2'd2, 1'b0, 12'h040, 32'h0, 1'b0, 1'b1);
        issue(0, "st_h_041", 1'b1, 2'd1, 1'b0, 12'h041, 32'h0000BEEF, 1'b0, 1'b1);
        issue(0, "ld_w_040b", 1'b0, 2'd2, 1'b0, 12'h040, 32'h0, 1'b0, 1'b1);
        issue(0, "ld_w_022", 1'b0, 2'd2, 1'b0, 12'h022, 32'h0, 1'b0, 1'b1);
        issue(0, "ld_hz_021", 1'b0, 2'd1, 1'b0, 12'h021, 32'h0, 1'b0, 1'b1);
        drain(0, "tail");

        repeat (5) @(negedge clk);
        #1;
        chk("final_sb0", 32'(sb[0].size()), 32'd0);
        chk("final_sb1", 32'(sb[1].size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dm_param.md
Name: dm_param

Overview:
Parametrised successor to the 4 KiB word data memory: byte-addressed, with configurable depth and configurable access latency.
- Supports byte, halfword and word loads and stores, with sign or zero extension on loads.
- Uses a req/ready/rvalid handshake, so the pipeline's MEM stage can stall on a multi-cycle memory.
- Sits in the datapath between the EX/MEM and MEM/WB pipeline registers.

Parameters:
ADDR_W, 12, byte-address width; array depth = 2^(ADDR_W-2) 32-bit words
LATENCY, 1, BUSY cycles per access; legal range 1..15
INIT_ZERO, 1, 1 = array initialised to zero at time 0; 0 = left unknown

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req  in  1  access request; sampled only while ready=1
we  in  1  1 = store, 0 = load
size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
sext  in  1  loads only: 1 = sign-extend, 0 = zero-extend
addr  in  ADDR_W  byte address
din  in  32  store data, right-justified (byte in [7:0], half in [15:0])
ready  out  1  1 = IDLE, request can be accepted
rvalid  out  1  one-cycle completion pulse, for loads and stores
dout  out  32  load result (registered)
misalign  out  1  qualifies rvalid; 1 = access was misaligned

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ready=1, rvalid=0, dout=0, misalign=0, latency counter=0.
  - Array contents are not reset.
- States: IDLE and BUSY.
- Accept: in IDLE, a rising edge with req=1 latches addr, size, sext, we and din.
  - State moves to BUSY and the counter loads LATENCY-1.
  - ready=0 throughout BUSY; req is ignored while BUSY.
- BUSY: the counter decrements each edge. On the edge where counter==0:
  - Commit: a store writes the array; a load registers its result into dout.
  - Go to IDLE.
  - In the following cycle, rvalid=1 for exactly one cycle, with ready=1.
- Latency: request accepted at edge N → rvalid high during the cycle after edge N+LATENCY.
- Back-to-back: a request presented during the rvalid cycle is accepted at that cycle's closing edge. No bubble beyond LATENCY.
- Lanes are little-endian: addr[1:0]=0 selects bits [7:0]; word index = addr[ADDR_W-1:2].
- Stores:
  - Byte: writes only lane addr[1:0] with din[7:0].
  - Half: writes lanes {addr[1],0} and {addr[1],1} with din[15:0].
  - Word: writes all four lanes.
  - Unselected lanes are unchanged.
- Loads:
  - Extract the selected byte or half and extend it to 32 bits according to the latched sext. Word loads ignore sext.
  - dout holds its value until the next load commits; stores never change dout.
- rvalid=0 in all other cycles. misalign=0 whenever rvalid=0.
- Reset during BUSY: the access is abandoned, a pending store does not write, and no rvalid is produced.

Optional Feature:
DM_MISALIGN_TRAP_EN
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]≠0, completes with the normal latency.
  - The array is not written and dout is unchanged.
  - rvalid=1 together with misalign=1 in the completion cycle.
- Undefined:
  - Low address bits are forced aligned: addr[0] is ignored for halves, addr[1:0] for words.
  - misalign is tied to 0.

Test Plan:
- Reset, then idle: ready=1, rvalid=0, dout=0. Word load of addr 0x010 with LATENCY=1 → rvalid one cycle later, dout=0x00000000.
- Word store 0xDEADBEEF @0x020, then byte store 0x11 @0x021, then word load @0x020 → dout=0xDEAD11EF.
- After the previous test: byte load @0x023 with sext=1 → 0xFFFFFFDE; sext=0 → 0x000000DE. Half load @0x022 with sext=1 → 0xFFFFDEAD.
- LATENCY=3: req held continuously, issuing 4 accesses → ready low 3 cycles per access, rvalid pulses 4 cycles apart, no access lost or duplicated.
- Store 0x12345678 @0x040 accepted, rst_n pulsed low during BUSY → no rvalid. After reset, load @0x040 → 0x00000000.
- Half store to @0x041:
  - DM_MISALIGN_TRAP_EN defined → misalign=1 with rvalid, word at 0x040 unchanged.
  - Undefined → write lands at 0x040 [15:0], misalign=0.
